rc4_phase_sequencer: RTL

- Parametrised top-level sequencer for the RC4 key-search datapath. It runs N worker phases in order (default: key generator, S-init, scramble, decrypt) using a one-cycle start pulse and a done/fail handshake per phase.
- It muxes the active phase's bus onto the single S-memory port.
- It adds features the single-sequence controller lacked: go/abort control, restart-on-fail to a configurable phase, an attempt limit, a per-phase watchdog, and status/error reporting.

---
 rtl/rc4_seq_pkg.sv | 23 ++
 rtl/rc4_phase_sequencer_if.sv | 41 ++++
 rtl/rc4_ram_bus_mux.sv | 34 +++
 rtl/rc4_phase_sequencer.sv | 138 +++++++++++++
 4 files changed

// File: rtl/rc4_seq_pkg.sv
// Shared types and helpers for the RC4 phase sequencer.
package rc4_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } seq_state_t;

  typedef enum logic [1:0] {
    ERR_NONE       = 2'b00,
    ERR_FAIL_LIMIT = 2'b01,
    ERR_TIMEOUT    = 2'b10
  } err_code_t;

  // Phase index width: max(1, clog2(n)).
  function automatic int unsigned ph_width(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rc4_phase_sequencer_if.sv
// Control, handshake and memory-bus bundle between the sequencer and its phases.
interface rc4_phase_sequencer_if
  import rc4_seq_pkg::*;
#(
  parameter int unsigned NUM_PHASES = 4,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 8
) ();
  localparam int unsigned PH_W = ph_width(NUM_PHASES);

  logic                         go;
  logic                         abort;
  logic [NUM_PHASES-1:0]        done_i;
  logic [NUM_PHASES-1:0]        fail_i;
  logic [NUM_PHASES*ADDR_W-1:0] ph_addr_i;
  logic [NUM_PHASES*DATA_W-1:0] ph_data_i;
  logic [NUM_PHASES-1:0]        ph_wren_i;
  logic [NUM_PHASES-1:0]        start_o;
  logic [ADDR_W-1:0]            ram_addr;
  logic [DATA_W-1:0]            ram_data;
  logic                         ram_wren;
  logic                         busy;
  logic                         done;
  logic                         error;
  logic [1:0]                   err_code;
  logic [PH_W-1:0]              phase;
  logic [15:0]                  attempts;

  // Sequencer side.
  modport master (
    input  go, abort, done_i, fail_i, ph_addr_i, ph_data_i, ph_wren_i,
    output start_o, ram_addr, ram_data, ram_wren, busy, done, error, err_code, phase, attempts
  );

  // Controller / worker side.
  modport slave (
    output go, abort, done_i, fail_i, ph_addr_i, ph_data_i, ph_wren_i,
    input  start_o, ram_addr, ram_data, ram_wren, busy, done, error, err_code, phase, attempts
  );

endinterface

// File: rtl/rc4_ram_bus_mux.sv
// Selects one phase's memory bus onto the shared S-memory port; zero when disabled.
module rc4_ram_bus_mux
  import rc4_seq_pkg::*;
#(
  parameter int unsigned NUM_PHASES = 4,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 8
) (
  input  logic [ph_width(NUM_PHASES)-1:0] sel_i,
  input  logic                            en_i,
  input  logic [NUM_PHASES*ADDR_W-1:0]    ph_addr_i,
  input  logic [NUM_PHASES*DATA_W-1:0]    ph_data_i,
  input  logic [NUM_PHASES-1:0]           ph_wren_i,
  output logic [ADDR_W-1:0]               ram_addr_o,
  output logic [DATA_W-1:0]               ram_data_o,
  output logic                            ram_wren_o
);
  localparam int unsigned SelW = ph_width(NUM_PHASES);

  // Pick the selected slice; everything stays zero when not enabled.
  always_comb begin
    ram_addr_o = '0;
    ram_data_o = '0;
    ram_wren_o = 1'b0;
    for (int unsigned p = 0; p < NUM_PHASES; p++) begin
      if (en_i && (sel_i == SelW'(p))) begin
        ram_addr_o = ph_addr_i[p*ADDR_W +: ADDR_W];
        ram_data_o = ph_data_i[p*DATA_W +: DATA_W];
        ram_wren_o = ph_wren_i[p];
      end
    end
  end

endmodule

// File: rtl/rc4_phase_sequencer.sv
// Runs the worker phases in order with retry, attempt limit, watchdog and abort.
module rc4_phase_sequencer
  import rc4_seq_pkg::*;
#(
  parameter int unsigned           NUM_PHASES     = 4,
  parameter int unsigned           ADDR_W         = 8,
  parameter int unsigned           DATA_W         = 8,
  parameter int unsigned           RESTART_PHASE  = 0,
  parameter logic [NUM_PHASES-1:0] FAIL_MASK      = 4'b1000,
  parameter int unsigned           MAX_ATTEMPTS   = 0,
  parameter int unsigned           TIMEOUT_CYCLES = 0,
  parameter int unsigned           TMO_W          = 24
) (
  input logic                   clk,
  input logic                   reset,
  rc4_phase_sequencer_if.master bus
);
  localparam int unsigned      PH_W         = ph_width(NUM_PHASES);
  localparam logic [PH_W-1:0]  LastPhase    = PH_W'(NUM_PHASES - 1);
  localparam logic [PH_W-1:0]  RestartPhase = PH_W'(RESTART_PHASE);
  localparam logic [15:0]      MaxAttempts  = 16'(MAX_ATTEMPTS);
  localparam logic [TMO_W-1:0] TmoLast      = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam bit               TmoEn        = (TIMEOUT_CYCLES != 0);
  localparam bit               LimitEn      = (MAX_ATTEMPTS != 0);

  seq_state_t            state_q, state_d;
  logic [PH_W-1:0]       phase_q, phase_d;
  logic [15:0]           attempts_q, attempts_d;
  err_code_t             err_q, err_d;
  logic [TMO_W-1:0]      wdog_q, wdog_d;
  logic [NUM_PHASES-1:0] start_vec;
  logic                  act_done, act_fail, tmo_hit, limit_hit;
  logic [15:0]           attempts_inc;
  logic                  busy_w;

  // State registers; asynchronous reset drops everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      attempts_q <= '0;
      err_q      <= ERR_NONE;
      wdog_q     <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      attempts_q <= attempts_d;
      err_q      <= err_d;
      wdog_q     <= wdog_d;
    end
  end

  // Next-state and start pulse; only the active phase's done/fail are looked at.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    attempts_d   = attempts_q;
    err_d        = err_q;
    wdog_d       = wdog_q;
    start_vec    = '0;
    act_done     = bus.done_i[phase_q];
    act_fail     = bus.fail_i[phase_q] & FAIL_MASK[phase_q];
    tmo_hit      = TmoEn && (wdog_q == TmoLast);
    limit_hit    = LimitEn && ((attempts_q + 16'd1) == MaxAttempts);
    attempts_inc = (attempts_q == 16'hFFFF) ? attempts_q : attempts_q + 16'd1;

    // Abort wins over go and every WAIT event; status registers hold.
    if (bus.abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE, DONE, ERROR: begin
          if (bus.go) begin
            phase_d    = '0;
            attempts_d = '0;
            err_d      = ERR_NONE;
            state_d    = START;
          end
        end
        START: begin
          start_vec[phase_q] = 1'b1;
          wdog_d             = '0;
          state_d            = WAIT;
        end
        WAIT: begin
          wdog_d = (wdog_q == '1) ? wdog_q : wdog_q + 1'b1;
          if (act_done) begin
            if (phase_q == LastPhase) begin
              state_d = DONE;
            end else begin
              phase_d = phase_q + 1'b1;
              state_d = START;
            end
          end else if (act_fail) begin
            attempts_d = attempts_inc;
            if (limit_hit) begin
              err_d   = ERR_FAIL_LIMIT;
              state_d = ERROR;
            end else begin
              phase_d = RestartPhase;
              state_d = START;
            end
          end else if (tmo_hit) begin
            err_d   = ERR_TIMEOUT;
            state_d = ERROR;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy_w = (state_q == START) || (state_q == WAIT);

  rc4_ram_bus_mux #(
    .NUM_PHASES (NUM_PHASES),
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W)
  ) u_mux (
    .sel_i      (phase_q),
    .en_i       (busy_w),
    .ph_addr_i  (bus.ph_addr_i),
    .ph_data_i  (bus.ph_data_i),
    .ph_wren_i  (bus.ph_wren_i),
    .ram_addr_o (bus.ram_addr),
    .ram_data_o (bus.ram_data),
    .ram_wren_o (bus.ram_wren)
  );

  assign bus.start_o  = start_vec;
  assign bus.busy     = busy_w;
  assign bus.done     = (state_q == DONE);
  assign bus.error    = (state_q == ERROR);
  assign bus.err_code = err_q;
  assign bus.phase    = phase_q;
  assign bus.attempts = attempts_q;

endmodule
